// File: rtl/mac_vector_feeder_pkg.sv
// Shared types and default widths for the MAC vector feeder and its operand buffers.
package mac_pkg;

  localparam int DEFAULT_WIDTH     = 10;
  localparam int DEFAULT_OUT_WIDTH = 20;
  localparam int DEFAULT_VEC_LEN   = 4;

  typedef logic signed [DEFAULT_WIDTH-1:0]     operand_t;
  typedef logic signed [DEFAULT_OUT_WIDTH-1:0] result_t;

  typedef enum logic [2:0] {
    CLEAR,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/mac_vector_feeder_if.sv
// Load port, MAC-side port and result port of the feeder bundled as one interface.
interface mac_vector_feeder_if
  import mac_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
);

  logic signed [WIDTH-1:0]     s_data;
  logic                        s_valid;
  logic                        s_ready;

  logic signed [WIDTH-1:0]     mac_a;
  logic signed [WIDTH-1:0]     mac_b;
  logic                        mac_valid_in;
  logic                        mac_clear;
  logic signed [OUT_WIDTH-1:0] mac_f;
  logic                        mac_valid_out;

  logic signed [OUT_WIDTH-1:0] m_data;
  logic                        m_valid;
  logic                        m_ready;

  // The feeder is the slave of the loader and owns the MAC controls and result port.
  modport slave (
    input  s_data, s_valid, mac_f, mac_valid_out, m_ready,
    output s_ready, mac_a, mac_b, mac_valid_in, mac_clear, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, mac_f, mac_valid_out, m_ready,
    input  s_ready, mac_a, mac_b, mac_valid_in, mac_clear, m_data, m_valid
  );

endinterface

// File: rtl/mac_vector_feeder_vec_buf.sv
// Small operand register file: one synchronous write port, one combinational read port.
module vec_buf #(
  parameter  int WIDTH  = 10,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_vector_feeder.sv
// Buffers two operand vectors, streams them into the MAC, captures the final dot product
// and offers it on a valid/ready port before clearing the MAC for the next pair.
module mac_vector_feeder
  import mac_pkg::*;
#(
  parameter  int WIDTH     = DEFAULT_WIDTH,
  parameter  int OUT_WIDTH = DEFAULT_OUT_WIDTH,
  parameter  int VEC_LEN   = DEFAULT_VEC_LEN,
  localparam int ADDR_W    = $clog2(VEC_LEN)
) (
  input logic                clk,
  input logic                reset,
  mac_vector_feeder_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(VEC_LEN - 1);
  localparam logic [ADDR_W:0]   LOAD_LAST = (ADDR_W + 1)'(2 * VEC_LEN - 1);
  localparam logic [ADDR_W:0]   B_BASE    = (ADDR_W + 1)'(VEC_LEN);

  feeder_state_t state;

  logic [ADDR_W:0]         load_cnt;
  logic [ADDR_W-1:0]       elem_cnt;
  logic [ADDR_W-1:0]       vout_cnt;

  logic                    s_ready_r;
  logic [WIDTH-1:0]        mac_a_r;
  logic [WIDTH-1:0]        mac_b_r;
  logic                    mac_valid_in_r;
  logic                    mac_clear_r;
  logic [OUT_WIDTH-1:0]    m_data_r;
  logic                    m_valid_r;

  logic                    load_fire;
  logic                    wr_a;
  logic                    wr_b;
  logic [ADDR_W-1:0]       b_wr_addr;
  logic [WIDTH-1:0]        rd_a;
  logic [WIDTH-1:0]        rd_b;

  // s_ready is only ever high in LOAD, so the handshake alone qualifies a write.
  assign load_fire = bus.s_valid && s_ready_r;
  assign wr_a      = load_fire && (load_cnt < B_BASE);
  assign wr_b      = load_fire && (load_cnt >= B_BASE);
  assign b_wr_addr = ADDR_W'(load_cnt - B_BASE);

  vec_buf #(
    .WIDTH (WIDTH),
    .DEPTH (VEC_LEN)
  ) u_buf_a (
    .clk     (clk),
    .wr_en   (wr_a),
    .wr_addr (load_cnt[ADDR_W-1:0]),
    .wr_data (bus.s_data),
    .rd_addr (elem_cnt),
    .rd_data (rd_a)
  );

  vec_buf #(
    .WIDTH (WIDTH),
    .DEPTH (VEC_LEN)
  ) u_buf_b (
    .clk     (clk),
    .wr_en   (wr_b),
    .wr_addr (b_wr_addr),
    .wr_data (bus.s_data),
    .rd_addr (elem_cnt),
    .rd_data (rd_b)
  );

  // The valid_out counter starts on STREAM entry because the first MAC pulse lands
  // two cycles after the first issue, while later elements are still streaming.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CLEAR;
      load_cnt       <= '0;
      elem_cnt       <= '0;
      vout_cnt       <= '0;
      s_ready_r      <= 1'b0;
      mac_a_r        <= '0;
      mac_b_r        <= '0;
      mac_valid_in_r <= 1'b0;
      mac_clear_r    <= 1'b1;
      m_data_r       <= '0;
      m_valid_r      <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          mac_clear_r <= 1'b0;
          s_ready_r   <= 1'b1;
          load_cnt    <= '0;
          state       <= LOAD;
        end
        LOAD: begin
          if (load_fire) begin
            if (load_cnt == LOAD_LAST) begin
              s_ready_r <= 1'b0;
              load_cnt  <= '0;
              elem_cnt  <= '0;
              vout_cnt  <= '0;
              state     <= STREAM;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        STREAM: begin
          mac_a_r        <= rd_a;
          mac_b_r        <= rd_b;
          mac_valid_in_r <= 1'b1;
          if (bus.mac_valid_out && (vout_cnt != LAST_IDX)) begin
            vout_cnt <= vout_cnt + 1'b1;
          end
          if (elem_cnt == LAST_IDX) begin
            elem_cnt <= '0;
            state    <= DRAIN;
          end else begin
            elem_cnt <= elem_cnt + 1'b1;
          end
        end
        DRAIN: begin
          mac_valid_in_r <= 1'b0;
          if (bus.mac_valid_out) begin
            if (vout_cnt == LAST_IDX) begin
              m_data_r  <= bus.mac_f;
              m_valid_r <= 1'b1;
              vout_cnt  <= '0;
              state     <= DONE;
            end else begin
              vout_cnt <= vout_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.m_ready) begin
            m_valid_r   <= 1'b0;
            mac_clear_r <= 1'b1;
            state       <= CLEAR;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  assign bus.s_ready      = s_ready_r;
  assign bus.mac_a        = mac_a_r;
  assign bus.mac_b        = mac_b_r;
  assign bus.mac_valid_in = mac_valid_in_r;
  assign bus.mac_clear    = mac_clear_r;
  assign bus.m_data       = m_data_r;
  assign bus.m_valid      = m_valid_r;

endmodule

// File: tb/tb_mac_vector_feeder.sv
// Bench for mac_vector_feeder: a behavioural 2-stage MAC closes the loop, results are
// compared against a plain dot-product model computed modulo 2^OUT_WIDTH.
module tb_mac_vector_feeder;

  localparam int WIDTH     = 10;
  localparam int OUT_WIDTH = 20;
  localparam int VEC_LEN   = 4;
  localparam int LATENCY   = VEC_LEN + 3;

  typedef int vec_t [VEC_LEN];

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mac_vector_feeder_if #(.WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  mac_vector_feeder #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .VEC_LEN   (VEC_LEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Environment MAC: registered product, then accumulate; valid_out two cycles after valid_in.
  logic signed [WIDTH-1:0]     mac_op_a;
  logic signed [WIDTH-1:0]     mac_op_b;
  logic signed [OUT_WIDTH-1:0] mac_prod;
  logic signed [OUT_WIDTH-1:0] mac_acc;
  logic                        mac_pv;
  logic                        mac_vo;

  assign mac_op_a = bus.mac_a;
  assign mac_op_b = bus.mac_b;

  always @(posedge clk) begin
    if (bus.mac_clear) begin
      mac_prod <= '0;
      mac_pv   <= 1'b0;
      mac_acc  <= '0;
      mac_vo   <= 1'b0;
    end else begin
      mac_prod <= mac_op_a * mac_op_b;
      mac_pv   <= bus.mac_valid_in;
      if (mac_pv) mac_acc <= mac_acc + mac_prod;
      mac_vo   <= mac_pv;
    end
  end

  assign bus.mac_f         = mac_acc;
  assign bus.mac_valid_out = mac_vo;

  int cyc = 0;
  int vin_pulses = 0;
  int clear_pulses = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && bus.mac_valid_in) vin_pulses <= vin_pulses + 1;
    if (!reset && bus.mac_clear)    clear_pulses <= clear_pulses + 1;
  end

  function automatic logic [OUT_WIDTH-1:0] dot_ref(input vec_t a, input vec_t b);
    longint s = 0;
    for (int i = 0; i < VEC_LEN; i++) s += longint'(a[i]) * longint'(b[i]);
    return OUT_WIDTH'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input vec_t a, input vec_t b, input bit gaps,
                           output bit ok, output int t_last);
    int w;
    ok = 1'b1;
    t_last = 0;
    for (int i = 0; i < 2 * VEC_LEN; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        bus.s_valid = 1'b0;
        bus.s_data  = WIDTH'($urandom);
        tick();
      end
      bus.s_data  = (i < VEC_LEN) ? WIDTH'(a[i]) : WIDTH'(b[i - VEC_LEN]);
      bus.s_valid = 1'b1;
      w = 0;
      while (bus.s_ready !== 1'b1 && w < 50) begin
        tick();
        w++;
      end
      if (bus.s_ready !== 1'b1) begin
        bus.s_valid = 1'b0;
        ok = 1'b0;
        return;
      end
      tick();
    end
    bus.s_valid = 1'b0;
    t_last = cyc;
  endtask

  task automatic wait_result(input int limit, output bit got);
    got = 1'b0;
    for (int n = 0; n < limit; n++) begin
      tick();
      if (bus.m_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.s_ready, bus.mac_valid_in, bus.m_valid, bus.mac_clear} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want 0001",
               {bus.s_ready, bus.mac_valid_in, bus.m_valid, bus.mac_clear});
    end
    checks++;
    if ({bus.mac_a, bus.mac_b} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_operands got %h/%h want 0/0", bus.mac_a, bus.mac_b);
    end
    checks++;
    if (bus.m_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_m_data got %h want 0", bus.m_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.s_ready, bus.mac_clear} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL release_load got %b want 10", {bus.s_ready, bus.mac_clear});
    end
  endtask

  task automatic test_directed();
    vec_t ta [4];
    vec_t tb [4];
    logic [OUT_WIDTH-1:0] exp;
    bit ok, got;
    int t_last, base;
    ta[0] = '{1, 2, 3, 4};           tb[0] = '{5, 6, 7, 8};
    ta[1] = '{-3, 4, -5, 6};         tb[1] = '{7, -8, 9, 10};
    ta[2] = '{-512, -512, -512, -512}; tb[2] = '{-512, -512, -512, -512};
    ta[3] = '{511, 511, 511, 511};   tb[3] = '{511, 511, 511, 511};
    bus.m_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp  = dot_ref(ta[t], tb[t]);
      base = vin_pulses;
      load_pair(ta[t], tb[t], 1'b0, ok, t_last);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL directed%0d_load s_ready got 0 want 1", t);
        continue;
      end
      wait_result(40, got);
      checks++;
      if (!got) begin
        errors++;
        $display("[TB] FAIL directed%0d_timeout m_valid got 0 want 1", t);
        continue;
      end
      checks++;
      if (cyc - t_last != LATENCY) begin
        errors++;
        $display("[TB] FAIL directed%0d_latency got %0d want %0d", t, cyc - t_last, LATENCY);
      end
      checks++;
      if (bus.m_data !== exp) begin
        errors++;
        $display("[TB] FAIL directed%0d_data got %h want %h", t, bus.m_data, exp);
      end
      checks++;
      if (vin_pulses - base != VEC_LEN) begin
        errors++;
        $display("[TB] FAIL directed%0d_pulses got %0d want %0d", t, vin_pulses - base, VEC_LEN);
      end
      tick();
      checks++;
      if (bus.m_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL directed%0d_one_cycle m_valid got %b want 0", t, bus.m_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t a = '{1, 2, 3, 4};
    vec_t b = '{5, 6, 7, 8};
    logic [OUT_WIDTH-1:0] exp;
    bit ok, got;
    int t_last, base;
    exp  = dot_ref(a, b);
    base = vin_pulses;
    bus.m_ready = 1'b0;
    load_pair(a, b, 1'b1, ok, t_last);
    wait_result(40, got);
    checks++;
    if (!ok || !got) begin
      errors++;
      $display("[TB] FAIL bp_result load_ok %b got_valid %b want 1 1", ok, got);
      bus.m_ready = 1'b1;
      return;
    end
    bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.s_data = WIDTH'($urandom);
      tick();
      checks++;
      if ({bus.m_valid, bus.s_ready} !== 2'b10 || bus.m_data !== exp) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d valid/ready %b data %h want 10 %h",
                 i, {bus.m_valid, bus.s_ready}, bus.m_data, exp);
      end
    end
    bus.s_valid = 1'b0;
    checks++;
    if (vin_pulses - base != VEC_LEN) begin
      errors++;
      $display("[TB] FAIL bp_pulses got %0d want %0d", vin_pulses - base, VEC_LEN);
    end
    bus.m_ready = 1'b1;
    tick();
    checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release m_valid got %b want 0", bus.m_valid);
    end
  endtask

  task automatic test_back_to_back();
    vec_t a1 = '{1, 2, 3, 4};
    vec_t b1 = '{5, 6, 7, 8};
    vec_t a2 = '{-3, 4, -5, 6};
    vec_t b2 = '{7, -8, 9, 10};
    bit ok1, ok2, got1, got2;
    int t_last, clr_base;
    logic [OUT_WIDTH-1:0] r1, r2;
    bus.m_ready = 1'b1;
    load_pair(a1, b1, 1'b0, ok1, t_last);
    wait_result(40, got1);
    r1 = bus.m_data;
    clr_base = clear_pulses;
    load_pair(a2, b2, 1'b0, ok2, t_last);
    wait_result(40, got2);
    r2 = bus.m_data;
    checks++;
    if (!(ok1 && ok2 && got1 && got2)) begin
      errors++;
      $display("[TB] FAIL b2b_handshake got %b want 1111", {ok1, ok2, got1, got2});
    end
    checks++;
    if (r1 !== dot_ref(a1, b1)) begin
      errors++;
      $display("[TB] FAIL b2b_first got %h want %h", r1, dot_ref(a1, b1));
    end
    checks++;
    if (r2 !== dot_ref(a2, b2)) begin
      errors++;
      $display("[TB] FAIL b2b_second got %h want %h", r2, dot_ref(a2, b2));
    end
    checks++;
    if (clear_pulses - clr_base != 1) begin
      errors++;
      $display("[TB] FAIL b2b_clear_count got %0d want 1", clear_pulses - clr_base);
    end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    vec_t a = '{1, 2, 3, 4};
    vec_t b = '{5, 6, 7, 8};
    bit ok, got;
    int t_last;
    bus.m_ready = 1'b1;
    load_pair(a, b, 1'b0, ok, t_last);
    tick();
    tick();
    checks++;
    if (bus.mac_valid_in !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_streaming mac_valid_in got %b want 1", bus.mac_valid_in);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.s_ready, bus.mac_valid_in, bus.m_valid, bus.mac_clear} !== 4'b0001 ||
        {bus.mac_a, bus.mac_b} !== '0 || bus.m_data !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset ctrl %b a %h b %h data %h want 0001 0 0 0",
               {bus.s_ready, bus.mac_valid_in, bus.m_valid, bus.mac_clear},
               bus.mac_a, bus.mac_b, bus.m_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.s_ready, bus.mac_clear} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL mid_reload got %b want 10", {bus.s_ready, bus.mac_clear});
    end
    load_pair(a, b, 1'b0, ok, t_last);
    wait_result(40, got);
    checks++;
    if (!ok || !got || bus.m_data !== dot_ref(a, b)) begin
      errors++;
      $display("[TB] FAIL mid_result ok %b valid %b data %h want 1 1 %h",
               ok, got, bus.m_data, dot_ref(a, b));
    end
    tick();
  endtask

  task automatic test_random();
    vec_t a, b;
    logic [OUT_WIDTH-1:0] exp;
    bit ok, got;
    int t_last, base, delay;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        a[i] = int'($urandom_range(0, 1023)) - 512;
        b[i] = int'($urandom_range(0, 1023)) - 512;
      end
      exp   = dot_ref(a, b);
      delay = int'($urandom_range(0, 3));
      base  = vin_pulses;
      bus.m_ready = (delay == 0);
      load_pair(a, b, 1'($urandom_range(0, 1)), ok, t_last);
      wait_result(40, got);
      checks++;
      if (!ok || !got) begin
        errors++;
        $display("[TB] FAIL rand%0d_handshake ok %b valid %b want 1 1", r, ok, got);
        bus.m_ready = 1'b1;
        continue;
      end
      checks++;
      if (bus.m_data !== exp || cyc - t_last != LATENCY) begin
        errors++;
        $display("[TB] FAIL rand%0d_result data %h lat %0d want %h %0d",
                 r, bus.m_data, cyc - t_last, exp, LATENCY);
      end
      repeat (delay) tick();
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp || vin_pulses - base != VEC_LEN) begin
        errors++;
        $display("[TB] FAIL rand%0d_hold valid %b data %h pulses %0d want 1 %h %0d",
                 r, bus.m_valid, bus.m_data, vin_pulses - base, exp, VEC_LEN);
      end
      bus.m_ready = 1'b1;
      tick();
      checks++;
      if (bus.m_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand%0d_release m_valid got %b want 0", r, bus.m_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_stream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
